pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised elastic pipeline register for inter-stage boundaries (EX/MEM first user).
//  Carries a control field and a data payload through STAGES slots with valid/ready handshake.
//  Supports stall (back-pressure), flush (bubble insertion) and occupancy reporting.
//  Bubbles always present all-zero control, so squashed slots never write memory or the regfile.
// PARAMETERS
//  CTRL_W  6    control bits: Branch, Zero, MemRead, MemWrite, MemtoReg, RegWrite
//  DATA_W  197  payload bits: Adder_Out_2(64), Result(64), Write_Data(64), RD(5)
//  STAGES  1    number of register slots in series (legal range 1..8)
// PORTS
//  clk        in   1                  clock; all state updates on rising edge
//  reset      in   1                  asynchronous, active-high
//  flush      in   1                  synchronous squash of all held entries
//  in_valid   in   1                  upstream entry present
//  in_ready   out  1                  block accepts entry this cycle
//  in_ctrl    in   CTRL_W             upstream control bits
//  in_data    in   DATA_W             upstream payload
//  out_valid  out  1                  head entry present
//  out_ready  in   1                  downstream accepts head entry
//  out_ctrl   out  CTRL_W             head control; forced 0 when out_valid=0
//  out_data   out  DATA_W             head payload; don't-care when out_valid=0
//  occupancy  out  $clog2(2*STAGES+1) number of valid entries held
// BEHAVIOUR
//  - Reset (async): every slot valid=0, ctrl=0, data=0; out_valid=0, out_ctrl=0, occupancy=0.
//  - Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
//  - Slot k advances when slot k+1 is empty or advancing; last slot advances on out_ready.
//  - Latency: STAGES cycles from in transfer to out_valid, with out_ready held 1.
//  - Throughput: 1 entry/cycle sustained, with in_valid=out_ready=1.
//  - Stall: while out_valid & !out_ready, out_ctrl and out_data are held stable.
//    No entry is lost or duplicated.
//  - Empty slots absorb stalls (bubble collapse): in_ready=1 while any slot can still advance.
//  - Flush: at the posedge all slot valid bits and ctrl fields clear; data regs may keep values.
//    in_ready=0 during the flush cycle; in_valid is ignored.
//    A head transfer (out_valid & out_ready) in the flush cycle completes; all else is squashed.
//  - reset and flush together: reset dominates.
//  - occupancy: registered count of valid bits. +1 on in transfer, -1 on out transfer, 0 on flush.
//    Simultaneous in and out transfers leave it unchanged.
//  - Ctrl zeroing: ctrl is written 0 whenever a slot loads a bubble, so out_ctrl is 0 for bubbles.
// CONFIGURATION
//  PIPE_SKID_EN defined:
//    - Each slot gains one skid entry; occupancy range becomes 0..2*STAGES.
//    - in_ready is driven directly from a flop: no combinational path from out_ready.
//    - Full throughput is kept across stall release.
//  PIPE_SKID_EN undefined:
//    - No skid entries; occupancy range 0..STAGES.
//    - in_ready = !valid[0] | advance[0], a combinational chain through out_ready.
//  Both builds have identical transfer ordering and flush/reset semantics.
// STRUCTURE
//  - pipe_pkg holds shared constants:
//      CTRL_BRANCH=0, CTRL_ZERO=1, CTRL_MEMREAD=2, CTRL_MEMWRITE=3, CTRL_MEMTOREG=4, CTRL_REGWRITE=5
//      EX_MEM_CTRL_W=6, EX_MEM_DATA_W=197
//      typedef of the EX/MEM payload struct
//  - Sub-module pipe_slot: one slot (valid, ctrl, data, optional skid entry, flush).
//    pipe_stage_reg instantiates a generate chain of STAGES pipe_slot instances
//    plus the occupancy counter.
// TESTING
//  1. Assert reset mid-stream with 2 entries held.
//     -> out_valid=0, out_ctrl=0, occupancy=0 the same cycle, asynchronously.
//  2. STAGES=3; in_valid=1 with ctrl=6'b100000 and data=1..10; out_ready=1.
//     -> out_data=1..10 in order, first at cycle 3; occupancy steady at 3.
//  3. Drop out_ready for 4 cycles while streaming.
//     -> out_data held; in_ready falls after the free slots fill; no loss or duplication after release.
//  4. Flush with 3 valid entries, out_ready=0.
//     -> next cycle out_valid=0, out_ctrl=0, occupancy=0; a MemWrite=1 entry never appears.
//  5. Flush and reset in the same cycle -> reset state.
//     Flush with out_ready=1 -> head consumed, the rest squashed.
//  6. PIPE_SKID_EN build: toggle out_ready randomly for 1000 cycles.
//     -> scoreboard matches the in-order stream; in_ready has no combinational dependency on out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants and the EX/MEM payload type for pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Control-field bit positions
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_ZERO     = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_REGWRITE = 5;

    localparam int EX_MEM_CTRL_W = 6;
    localparam int EX_MEM_DATA_W = 197;

    typedef struct packed {
        logic [63:0] adder_out_2;
        logic [63:0] result;
        logic [63:0] write_data;
        logic [4:0]  rd;
    } ex_mem_payload_t;

    // True when an entry with this control would change architectural state.
    function automatic logic ctrl_has_side_effect(input logic [EX_MEM_CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMWRITE] | ctrl[CTRL_REGWRITE];
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_slot.sv
// ============================================================================
// Module   : pipe_slot
// Purpose  : One elastic register slot (valid/ctrl/data) with flush; optional
//            skid entry selected by macro PIPE_SKID_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);

    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    assign out_valid = valid;
    assign out_ctrl  = ctrl;
    assign out_data  = data;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              load;

    // Main register refills whenever it is empty or its entry leaves.
    assign load     = !valid || out_ready;
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            ctrl       <= '0;
            data       <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            ctrl       <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
        end else if (load) begin
            if (skid_valid) begin
                valid      <= 1'b1;
                ctrl       <= skid_ctrl;
                data       <= skid_data;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else begin
                valid <= in_valid;
                ctrl  <= in_valid ? in_ctrl : '0;
                if (in_valid) begin
                    data <= in_data;
                end
            end
        end else if (in_valid && !skid_valid) begin
            // Main is stalled: park the incoming entry so in_ready stays registered.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end
`else
    assign in_ready = !valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (in_ready) begin
            valid <= in_valid;
            ctrl  <= in_valid ? in_ctrl : '0;
            if (in_valid) begin
                data <= in_data;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Elastic STAGES-deep pipeline register with stall, flush and
//            occupancy; macro PIPE_SKID_EN adds a skid entry per slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = EX_MEM_DATA_W,
    parameter int STAGES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CTRL_W-1:0]                in_ctrl,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CTRL_W-1:0]                out_ctrl,
    output logic [DATA_W-1:0]                out_data,
    output logic [$clog2(2*STAGES+1)-1:0]    occupancy
);

    localparam int OCC_W = $clog2(2*STAGES+1);

    // Index k is the boundary feeding slot k; index STAGES is the block output.
    logic [STAGES:0]             vld;
    logic [STAGES:0]             rdy;
    logic [STAGES:0][CTRL_W-1:0] ctl;
    logic [STAGES:0][DATA_W-1:0] dat;

    assign vld[0]      = in_valid;
    assign ctl[0]      = in_ctrl;
    assign dat[0]      = in_data;
    assign rdy[STAGES] = out_ready;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slot
            pipe_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .flush     (flush),
                .in_valid  (vld[k]),
                .in_ready  (rdy[k]),
                .in_ctrl   (ctl[k]),
                .in_data   (dat[k]),
                .out_valid (vld[k+1]),
                .out_ready (rdy[k+1]),
                .out_ctrl  (ctl[k+1]),
                .out_data  (dat[k+1])
            );
        end
    endgenerate

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[STAGES];
    assign out_ctrl  = ctl[STAGES] & {CTRL_W{vld[STAGES]}};
    assign out_data  = dat[STAGES];

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg (STAGES=3), scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int CW = EX_MEM_CTRL_W;
    localparam int DW = EX_MEM_DATA_W;
    localparam int ST = 3;
    localparam int OW = $clog2(2*ST+1);
`ifdef PIPE_SKID_EN
    localparam int CAP = 2*ST;
`else
    localparam int CAP = ST;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [OW-1:0] occupancy;

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } sb_t;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          ov;
        logic [DW-1:0] odat;
        int            occ;
    } vec_t;

    sb_t  sb[$];
    vec_t vec[13];
    int   total = 0;
    int   bad = 0;
    int   n_sent = 0;
    logic saw;
    logic r0;

    pipe_stage_reg #(
        .CTRL_W (CW),
        .DATA_W (DW),
        .STAGES (ST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int n);
        logic [63:0] k;
        k = 64'(n);
        return {k * 64'h9E37_79B9_7F4A_7C15, ~k, k ^ 64'h5A5A_5A5A, k[4:0]};
    endfunction

    task automatic drive(input logic v, input logic r, input logic [CW-1:0] c);
        in_valid  = v;
        out_ready = r;
        in_ctrl   = c;
        in_data   = mk_data(n_sent);
        #1;
    endtask

    // One clock: sample handshakes at negedge, update scoreboard, check after the edge.
    task automatic cycle();
        logic do_in, do_out;
        sb_t  e;
        @(negedge clk);
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got out_valid=1 with ctrl=%0h want no entry", out_ctrl);
            end else begin
                check("head", 256'({out_ctrl, out_data}), 256'({sb[0].ctrl, sb[0].data}));
            end
        end else begin
            check("bubble_ctrl", 256'(out_ctrl), 256'(0));
        end
        if (flush) check("ready_in_flush", 256'(in_ready), 256'(0));
        do_out = out_valid && out_ready;
        do_in  = in_valid && in_ready && !flush;
        if (do_out && sb.size() > 0) void'(sb.pop_front());
        if (flush) begin
            sb.delete();
        end else if (do_in) begin
            e.ctrl = in_ctrl;
            e.data = in_data;
            sb.push_back(e);
            n_sent++;
        end
        @(posedge clk);
        #1;
        check("occupancy", 256'(occupancy), 256'(sb.size()));
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) cycle();
        check({tag, "_drain_left"}, 256'(sb.size()), 256'(0));
        check({tag, "_drain_occ"}, 256'(occupancy), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        for (int e = 0; e < 13; e++) begin
            vec[e].vld  = (e < 10);
            vec[e].dat  = DW'(e + 1);
            vec[e].ov   = (e >= 2 && e <= 11);
            vec[e].odat = DW'(e - 1);
            vec[e].occ  = (e < 2) ? e + 1 : (e <= 9) ? 3 : 12 - e;
        end

        #12;
        check("rst_hold_valid", 256'(out_valid), 256'(0));
        check("rst_hold_occ", 256'(occupancy), 256'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_ctrl", 256'(out_ctrl), 256'(0));
        check("rst_occ", 256'(occupancy), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));

        // Streaming table: data 1..10, first output after the third edge.
        for (int e = 0; e < 13; e++) begin
            in_valid  = vec[e].vld;
            in_ctrl   = 6'b100000;
            in_data   = vec[e].dat;
            out_ready = 1'b1;
            cycle();
            check("t2_out_valid", 256'(out_valid), 256'(vec[e].ov));
            if (vec[e].ov) check("t2_out_data", 256'(out_data), 256'(vec[e].odat));
            check("t2_occ", 256'(occupancy), 256'(vec[e].occ));
        end
        drain("t2");

        // Four-cycle stall while streaming.
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, !(c >= 5 && c < 9), CW'($urandom));
            if (c == 8) begin
                check("t3_in_ready_stalled", 256'(in_ready), 256'(0));
                check("t3_occ_full", 256'(occupancy), 256'(CAP));
            end
            cycle();
        end
        drain("t3");

        // Flush three held entries, the youngest carrying MemWrite.
        drive(1'b1, 1'b0, 6'b000001); cycle();
        drive(1'b1, 1'b0, 6'b100000); cycle();
        drive(1'b1, 1'b0, 6'b001000); cycle();
        flush = 1'b1;
        drive(1'b1, 1'b0, 6'b001000); cycle();
        flush = 1'b0;
        check("t4_out_valid", 256'(out_valid), 256'(0));
        check("t4_out_ctrl", 256'(out_ctrl), 256'(0));
        check("t4_occ", 256'(occupancy), 256'(0));
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, '0);
            cycle();
            if (out_valid || ctrl_has_side_effect(out_ctrl)) saw = 1'b1;
        end
        check("t4_memwrite_leak", 256'(saw), 256'(0));

        // Asynchronous reset with two entries held.
        drive(1'b1, 1'b0, 6'b010101); cycle();
        drive(1'b1, 1'b0, 6'b101010); cycle();
        check("t1_pre_occ", 256'(occupancy), 256'(2));
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("t1_async_valid", 256'(out_valid), 256'(0));
        check("t1_async_ctrl", 256'(out_ctrl), 256'(0));
        check("t1_async_occ", 256'(occupancy), 256'(0));
        sb.delete();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check("t1_post_valid", 256'(out_valid), 256'(0));

        // Flush and reset together.
        drive(1'b1, 1'b0, 6'b111111); cycle();
        drive(1'b1, 1'b0, 6'b111000); cycle();
        flush = 1'b1; reset = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rf_valid", 256'(out_valid), 256'(0));
        check("t5_rf_ctrl", 256'(out_ctrl), 256'(0));
        check("t5_rf_occ", 256'(occupancy), 256'(0));
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check("t5_rf_in_ready", 256'(in_ready), 256'(1));

        // Flush with out_ready=1: head completes, the rest are squashed.
        drive(1'b1, 1'b0, 6'b000011); cycle();
        drive(1'b1, 1'b0, 6'b001100); cycle();
        drive(1'b1, 1'b0, 6'b001000); cycle();
        flush = 1'b1;
        drive(1'b1, 1'b1, 6'b001000); cycle();
        flush = 1'b0;
        check("t5_fl_valid", 256'(out_valid), 256'(0));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, '0);
            cycle();
        end
        check("t5_fl_occ", 256'(occupancy), 256'(0));

        // Random handshakes.
        for (int i = 0; i < 1000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, CW'($urandom));
`ifdef PIPE_SKID_EN
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            check("t6_ready_vs_out_ready", 256'(in_ready), 256'(r0));
            out_ready = ~out_ready;
            #1;
`endif
            cycle();
        end
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
